// File: rtl/seg7_pkg.sv
// Shared types, glyph constants and the nibble-to-segment lookup for the
// multi-digit seven-segment driver. Segments are active-low, bit0=a .. bit6=g.
package seg7_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_LATCH
   } seg7_state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   function automatic logic [6:0] nibble_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seg7_digit_enc.sv
// One digit's segment encoder: dash overrides blank, blank overrides the glyph.
module seg7_digit_enc
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       blank,
   input  logic       dash,
   output logic [6:0] segs
);

   always_comb begin
      if (dash) begin
         segs = SEG_DASH;
      end else if (blank) begin
         segs = SEG_BLANK;
      end else begin
         segs = nibble_to_seg(nibble);
      end
   end

endmodule

// File: rtl/seg7_multi_display.sv
// Multi-digit seven-segment driver: accepts a binary value, converts it to BCD
// (one bit per clock) or maps hex nibbles, then updates every digit on one edge.
module seg7_multi_display
   import seg7_pkg::*;
#(
   parameter int DIGITS   = 6,
   parameter int BIN_W    = 20,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic                  Load,
   input  logic [BIN_W-1:0]      Value,
   input  logic                  HexMode,
   output logic                  Ready,
   output logic                  Overflow,
   output logic [7*DIGITS-1:0]   HexSegs
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int EXT_W = (BIN_W > BCD_W) ? BIN_W : BCD_W;
   localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);

   seg7_state_t        state;
   logic [BIN_W-1:0]   bin_q;
   logic [BCD_W-1:0]   bcd_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               ovf_q;
   logic               hex_q;

   logic [BCD_W-1:0]   bcd_adj;
   logic [BCD_W-1:0]   bcd_shift;
   logic [BIN_W-1:0]   bin_shift;
   logic               carry;

   logic [EXT_W-1:0]   val_ext;
   logic [BCD_W-1:0]   hex_nib;
   logic               hex_ovf;
   logic [BCD_W-1:0]   disp_nib;
   logic               disp_ovf;
   logic [DIGITS-1:0]  zero_above;
   logic [DIGITS-1:0]  blank;
   logic [7*DIGITS-1:0] seg_next;

   // One double-dabble step: correct every BCD digit, then shift {bcd,bin} left.
   always_comb begin
      // NOTE: assign a default before any conditional update so no path infers a latch.
      bcd_adj = bcd_q;
      for (int d = 0; d < DIGITS; d++) begin
         if (bcd_q[4*d +: 4] >= 4'd5) begin
            bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
         end
      end
      {carry, bcd_shift, bin_shift} = {bcd_adj, bin_q, 1'b0};
   end

   // In hex mode the captured value never shifts, so bin_q still holds it at LATCH.
   assign val_ext = EXT_W'(bin_q);
   assign hex_nib = val_ext[BCD_W-1:0];

   generate
      if (BIN_W > BCD_W) begin : g_hex_ovf
         assign hex_ovf = |val_ext[EXT_W-1:BCD_W];
      end else begin : g_no_hex_ovf
         assign hex_ovf = 1'b0;
      end
   endgenerate

   assign disp_nib = hex_q ? hex_nib : bcd_q;
   assign disp_ovf = hex_q ? hex_ovf : ovf_q;

   always_comb begin
      zero_above = '0;
      zero_above[DIGITS-1] = (disp_nib[4*(DIGITS-1) +: 4] == 4'd0);
      for (int i = DIGITS - 2; i >= 0; i--) begin
         zero_above[i] = zero_above[i+1] && (disp_nib[4*i +: 4] == 4'd0);
      end
   end

   generate
      for (genvar i = 0; i < DIGITS; i++) begin : g_digit
         // Digit 0 always shows something, so a zero value reads "0".
         assign blank[i] = BLANK_LZ && (i != 0) && zero_above[i];

         seg7_digit_enc u_enc (
            .nibble (disp_nib[4*i +: 4]),
            .blank  (blank[i]),
            .dash   (disp_ovf),
            .segs   (seg_next[7*i +: 7])
         );
      end
   endgenerate

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state    <= S_IDLE;
         bin_q    <= '0;
         bcd_q    <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         hex_q    <= 1'b0;
         Ready    <= 1'b1;
         Overflow <= 1'b0;
         HexSegs  <= '1;
      end else begin
         case (state)
            S_IDLE: begin
               if (Load) begin
                  bin_q <= Value;
                  hex_q <= HexMode;
                  bcd_q <= '0;
                  cnt_q <= '0;
                  ovf_q <= 1'b0;
                  Ready <= 1'b0;
                  state <= HexMode ? S_LATCH : S_SHIFT;
               end
            end
            S_SHIFT: begin
               bin_q <= bin_shift;
               bcd_q <= bcd_shift;
               cnt_q <= cnt_q + CNT_W'(1);
               if (carry) begin
                  ovf_q <= 1'b1;
               end
               if (cnt_q == LAST_SHIFT) begin
                  state <= S_LATCH;
               end
            end
            S_LATCH: begin
               HexSegs  <= seg_next;
               Overflow <= disp_ovf;
               Ready    <= 1'b1;
               state    <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seg7_multi_display.sv
// Randomised self-checking bench: two instances (leading-zero blanking on/off)
// compared against an arithmetic model of the displayed digits.
module tb_seg7_multi_display;

   localparam int DIGITS = 6;
   localparam int BIN_W  = 20;
   localparam int SEGW   = 7 * DIGITS;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              load = 1'b0;
   logic              hex_mode = 1'b0;
   logic [BIN_W-1:0]  value = '0;
   logic              ready_a, ovf_a, ready_b, ovf_b;
   logic [SEGW-1:0]   segs_a, segs_b;

   int n_cmp = 0;
   int n_bad = 0;

   logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   always #5 clk = ~clk;

   seg7_multi_display #(.DIGITS(DIGITS), .BIN_W(BIN_W), .BLANK_LZ(1'b1)) dut_a (
      .Clk(clk), .Reset_n(rst_n), .Load(load), .Value(value), .HexMode(hex_mode),
      .Ready(ready_a), .Overflow(ovf_a), .HexSegs(segs_a)
   );

   seg7_multi_display #(.DIGITS(DIGITS), .BIN_W(BIN_W), .BLANK_LZ(1'b0)) dut_b (
      .Clk(clk), .Reset_n(rst_n), .Load(load), .Value(value), .HexMode(hex_mode),
      .Ready(ready_b), .Overflow(ovf_b), .HexSegs(segs_b)
   );

   // Digits by repeated division; anything left over means the value did not fit.
   function automatic logic [SEGW-1:0] model_segs(input longint unsigned v, input bit hm,
                                                  input bit blz, output bit ovf);
      int unsigned d [DIGITS];
      longint unsigned rest = v;
      longint unsigned base = hm ? 16 : 10;
      int msd = 0;
      logic [SEGW-1:0] s;
      for (int i = 0; i < DIGITS; i++) begin
         d[i] = int'(rest % base);
         rest = rest / base;
      end
      ovf = (rest != 0);
      for (int i = 0; i < DIGITS; i++) if (d[i] != 0) msd = i;
      for (int i = 0; i < DIGITS; i++) begin
         if (ovf)                   s[7*i +: 7] = 7'h3F;
         else if (blz && i > msd)   s[7*i +: 7] = 7'h7F;
         else                       s[7*i +: 7] = glyph[d[i]];
      end
      return s;
   endfunction

   // Presents one Load pulse when idle and measures edges until Ready returns.
   task automatic send(input logic [BIN_W-1:0] v, input bit hm,
                       output bit accepted, output int lat, output bit stable);
      int guard = 0;
      logic [2*SEGW+1:0] snap;
      while (!ready_a && guard < 200) begin
         @(posedge clk); #1; guard++;
      end
      @(negedge clk);
      load = 1'b1; value = v; hex_mode = hm;
      @(posedge clk); #1;
      load = 1'b0;
      value = BIN_W'($urandom);
      hex_mode = 1'($urandom_range(0, 1));
      accepted = !ready_a && !ready_b;
      snap = {segs_a, segs_b, ovf_a, ovf_b};
      lat = 0;
      stable = 1'b1;
      while (!ready_a && lat < 200) begin
         @(posedge clk); #1; lat++;
         if (!ready_a && {segs_a, segs_b, ovf_a, ovf_b} !== snap) stable = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({segs_a, segs_b, ready_a, ready_b, ovf_a, ovf_b} !== {{2*SEGW{1'b1}}, 4'b1100}) begin
         n_bad++;
         $display("FAIL reset_hold: segs=%h/%h ready=%b/%b ovf=%b/%b, want all 1s ready=1 ovf=0",
                  segs_a, segs_b, ready_a, ready_b, ovf_a, ovf_b);
      end
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({segs_a, segs_b, ready_a, ready_b, ovf_a, ovf_b} !== {{2*SEGW{1'b1}}, 4'b1100}) begin
         n_bad++;
         $display("FAIL reset_release: segs=%h/%h ready=%b/%b ovf=%b/%b, want all 1s ready=1 ovf=0",
                  segs_a, segs_b, ready_a, ready_b, ovf_a, ovf_b);
      end
   endtask

   // Runs a table of transactions back to back and checks timing and display.
   task automatic run_table(input string name, input logic [BIN_W-1:0] vals [], input bit hms []);
      bit acc, stab, eo;
      int lat, exp_lat;
      logic [SEGW-1:0] ea, eb;
      for (int k = 0; k < vals.size(); k++) begin
         send(vals[k], hms[k], acc, lat, stab);
         ea = model_segs(vals[k], hms[k], 1'b1, eo);
         eb = model_segs(vals[k], hms[k], 1'b0, eo);
         exp_lat = hms[k] ? 1 : BIN_W + 1;
         n_cmp++;
         if (!(acc && stab && lat == exp_lat)) begin
            n_bad++;
            $display("FAIL %s_timing[%0d]: accepted=%b stable=%b latency=%0d, want 1 1 %0d",
                     name, k, acc, stab, lat, exp_lat);
         end
         n_cmp++;
         if ({segs_a, segs_b, ovf_a, ovf_b, ready_a, ready_b} !== {ea, eb, eo, eo, 2'b11}) begin
            n_bad++;
            $display("FAIL %s_value[%0d] v=%0d hex=%b: segs=%h/%h ovf=%b/%b ready=%b/%b, want %h/%h ovf=%b",
                     name, k, vals[k], hms[k], segs_a, segs_b, ovf_a, ovf_b, ready_a, ready_b,
                     ea, eb, eo);
         end
      end
   endtask

   task automatic test_decimal();
      run_table("dec_basic", '{20'd123456, 20'd999999, 20'd5}, '{1'b0, 1'b0, 1'b0});
   endtask

   task automatic test_back_to_back();
      run_table("back_to_back", '{20'd0, 20'd42}, '{1'b0, 1'b0});
   endtask

   task automatic test_overflow();
      run_table("overflow", '{20'd1000000, 20'd7, 20'hFFFFF, 20'd100000}, '{1'b0, 1'b0, 1'b0, 1'b0});
   endtask

   task automatic test_hex();
      run_table("hex", '{20'h0ABCD, 20'h00000, 20'hFFFFF, 20'h10000}, '{1'b1, 1'b1, 1'b1, 1'b1});
   endtask

   task automatic test_load_during_shift();
      bit eo;
      int lat = 0;
      logic [SEGW-1:0] ea, eb;
      @(negedge clk);
      load = 1'b1; value = 20'd654321; hex_mode = 1'b0;
      @(posedge clk); #1;
      load = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      load = 1'b1; value = 20'd5; hex_mode = 1'b1;
      repeat (4) @(posedge clk);
      #1 load = 1'b0;
      lat = 7;
      while (!ready_a && lat < 200) begin
         @(posedge clk); #1; lat++;
      end
      ea = model_segs(654321, 1'b0, 1'b1, eo);
      eb = model_segs(654321, 1'b0, 1'b0, eo);
      n_cmp++;
      if (lat != BIN_W + 1 || {segs_a, segs_b, ovf_a, ovf_b} !== {ea, eb, eo, eo}) begin
         n_bad++;
         $display("FAIL load_during_shift: latency=%0d segs=%h/%h ovf=%b/%b, want %0d %h/%h ovf=%b",
                  lat, segs_a, segs_b, ovf_a, ovf_b, BIN_W + 1, ea, eb, eo);
      end
   endtask

   task automatic test_reset_mid_shift();
      @(negedge clk);
      load = 1'b1; value = 20'd777777; hex_mode = 1'b0;
      @(posedge clk); #1;
      load = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      n_cmp++;
      if (ready_a !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_shift_busy: ready=%b, want 0", ready_a);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({segs_a, segs_b, ready_a, ready_b, ovf_a, ovf_b} !== {{2*SEGW{1'b1}}, 4'b1100}) begin
         n_bad++;
         $display("FAIL mid_shift_reset: segs=%h/%h ready=%b/%b ovf=%b/%b, want all 1s ready=1 ovf=0",
                  segs_a, segs_b, ready_a, ready_b, ovf_a, ovf_b);
      end
      @(negedge clk) rst_n = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      n_cmp++;
      if ({segs_a, segs_b, ready_a, ready_b, ovf_a, ovf_b} !== {{2*SEGW{1'b1}}, 4'b1100}) begin
         n_bad++;
         $display("FAIL mid_shift_no_stale: segs=%h/%h ready=%b/%b ovf=%b/%b, want all 1s ready=1 ovf=0",
                  segs_a, segs_b, ready_a, ready_b, ovf_a, ovf_b);
      end
   endtask

   task automatic test_random();
      logic [BIN_W-1:0] vals [];
      bit hms [];
      vals = new[30];
      hms  = new[30];
      for (int k = 0; k < 30; k++) begin
         hms[k] = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       vals[k] = BIN_W'($urandom_range(0, 99));
            1:       vals[k] = BIN_W'($urandom);
            2:       vals[k] = BIN_W'($urandom_range(999990, 1000009));
            default: vals[k] = BIN_W'(1) << $urandom_range(0, BIN_W - 1);
         endcase
      end
      run_table("random", vals, hms);
   endtask

   initial begin
      test_reset();
      test_decimal();
      test_back_to_back();
      test_overflow();
      test_hex();
      test_load_during_shift();
      test_reset_mid_shift();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
